// File: rtl/nn_layer_sequencer.sv
// Sequences a multi-layer network over one shared layer engine: validates the
// per-layer neuron counts, then issues each layer and waits for its completion.
module nn_layer_sequencer #(
    parameter int NR_LAYERS  = 2,
    parameter int INPUTSIZE  = 4,
    parameter int OUTPUTSIZE = 10,
    parameter int MAXWEIGHTS = 4,
    parameter int MAXRESULTS = 10,
    parameter int TIMEOUT    = 1024,
    localparam int IDX_W     = (NR_LAYERS > 1) ? $clog2(NR_LAYERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [32*NR_LAYERS-1:0] neuron_count,
    input  logic                    layer_done,
    output logic                    layer_start,
    output logic [IDX_W-1:0]        layer_idx,
    output logic [31:0]             layer_in_count,
    output logic [31:0]             layer_out_count,
    output logic                    buf_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_LAYERS - 1);
    localparam logic [31:0]      IN_W     = 32'(INPUTSIZE);
    localparam logic [31:0]      OUT_W    = 32'(OUTPUTSIZE);
    localparam logic [31:0]      MAXW_W   = 32'(MAXWEIGHTS);
    localparam logic [31:0]      MAXR_W   = 32'(MAXRESULTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t             state_q;
    logic [31:0]        snap_q [NR_LAYERS];
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   layer_idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               layer_start_q;
    logic [31:0]        in_count_q;
    logic [31:0]        out_count_q;
    logic               buf_sel_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         err_code_q;
    logic [NR_LAYERS-1:0] range_bad;
    logic               last_bad;

    // Layer k consumes layer k-1's outputs, so its input count is the previous neuron count.
    for (genvar gi = 0; gi < NR_LAYERS; gi++) begin : g_chk
        logic [31:0] out_cnt;
        logic [31:0] in_cnt;
        assign out_cnt = neuron_count[32*gi +: 32];
        if (gi == 0) begin : g_first
            assign in_cnt = IN_W;
        end else begin : g_rest
            assign in_cnt = neuron_count[32*(gi-1) +: 32];
        end
        assign range_bad[gi] = (out_cnt == 32'd0) || (out_cnt > MAXR_W) || (in_cnt > MAXW_W);
    end

    assign last_bad = (neuron_count[32*(NR_LAYERS-1) +: 32] != OUT_W);
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign idx_d    = layer_idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int k = 0; k < NR_LAYERS; k++) snap_q[k] <= '0;
            cnt_q         <= '0;
            layer_idx_q   <= '0;
            layer_start_q <= 1'b0;
            in_count_q    <= '0;
            out_count_q   <= '0;
            buf_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            layer_start_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                layer_idx_q <= '0;
                buf_sel_q   <= 1'b0;
                in_count_q  <= '0;
                out_count_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_CHECK;
                            busy_q     <= 1'b1;
                            err_code_q <= 2'd0;
                        end
                    end
                    S_CHECK: begin
                        for (int k = 0; k < NR_LAYERS; k++) snap_q[k] <= neuron_count[32*k +: 32];
                        if (|range_bad) begin
                            state_q    <= S_FAULT;
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                        end else if (last_bad) begin
                            state_q    <= S_FAULT;
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                        end else begin
                            // Counts come from the port here; the snapshot lands on this same edge.
                            state_q       <= S_ISSUE;
                            layer_start_q <= 1'b1;
                            layer_idx_q   <= '0;
                            buf_sel_q     <= 1'b0;
                            in_count_q    <= IN_W;
                            out_count_q   <= neuron_count[31:0];
                        end
                    end
                    S_ISSUE: begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (layer_done) begin
                            state_q <= S_ADVANCE;
                        end else if (cnt_d >= TMO_LAST) begin
                            state_q    <= S_FAULT;
                            err_q      <= 1'b1;
                            err_code_q <= 2'd3;
                            cnt_q      <= TMO_LAST;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_ADVANCE: begin
                        if (layer_idx_q == LAST_IDX) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_ISSUE;
                            layer_start_q <= 1'b1;
                            layer_idx_q   <= idx_d;
                            buf_sel_q     <= ~buf_sel_q;
                            in_count_q    <= out_count_q;
                            out_count_q   <= snap_q[idx_d];
                        end
                    end
                    S_FINISH, S_FAULT: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        layer_idx_q <= '0;
                        buf_sel_q   <= 1'b0;
                        in_count_q  <= '0;
                        out_count_q <= '0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign layer_start     = layer_start_q;
    assign layer_idx       = layer_idx_q;
    assign layer_in_count  = in_count_q;
    assign layer_out_count = out_count_q;
    assign buf_sel         = buf_sel_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;

endmodule
